// File: rtl/mdio_sequencer.sv
// MDIO management-frame sequencer: free-running MDC, PHY init
// table writes after reset, then single read/write commands.
module mdio_sequencer #(
  parameter int CLK_DIV  = 64,
  parameter int WAIT_MDC = 128,
  parameter int NUM_INIT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  PHYAD,
  input  logic [((NUM_INIT > 0) ? NUM_INIT : 1)*21-1:0] INIT_TABLE,
  output logic        MDC,
  output logic        MDIO_O,
  output logic        MDIO_T,
  input  logic        MDIO_I,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WR,
  input  logic [4:0]  CMD_REGAD,
  input  logic [15:0] CMD_WDATA,
  output logic        RD_VALID,
  output logic [15:0] RD_DATA,
  output logic        BUSY,
  output logic        COMPLETE
);

  localparam int NI = (NUM_INIT > 0) ? NUM_INIT : 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam int WW = (WAIT_MDC > 1) ? $clog2(WAIT_MDC) : 1;
  localparam int IW = (NI > 1) ? $clog2(NI) : 1;

  localparam logic [CW-1:0] DLAST = CW'(CLK_DIV - 1);
  localparam logic [WW-1:0] WLAST =
    WW'((WAIT_MDC > 0) ? WAIT_MDC - 1 : 0);
  localparam logic [IW-1:0] ILAST = IW'(NI - 1);

  typedef enum logic [1:0] {
    WAIT,
    INIT,
    READY,
    FRAME
  } state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic          mdc_q;
  logic [WW-1:0] wait_cnt;
  logic [IW-1:0] idx;
  logic [6:0]    bit_cnt;
  logic          busy_q;
  logic          mdio_o_q;
  logic          mdio_t_q;
  logic          cmd_ready_q;
  logic          complete_q;
  logic          rd_valid_q;
  logic          rd_pend;
  logic [15:0]   rd_data_q;
  logic [15:0]   rx_sh;

  logic          cmd_wr_q;
  logic [4:0]    cmd_regad_q;
  logic [15:0]   cmd_wdata_q;

  logic          fr_wr;
  logic [4:0]    fr_phy;
  logic [4:0]    fr_reg;
  logic [15:0]   fr_data;

  logic          tick;
  logic          fall;
  logic          rise;
  logic          wait_done;
  logic          last_bit;
  logic          start;
  logic [IW-1:0] nxt_idx;
  logic [20:0]   entry;
  logic          st_wr;
  logic [4:0]    st_reg;
  logic [15:0]   st_data;
  logic [31:0]   tx_word;
  logic [6:0]    nbit;
  logic          drv_o;
  logic          drv_t;

  assign tick      = (div_cnt == DLAST);
  assign fall      = tick & mdc_q;
  assign rise      = tick & ~mdc_q;
  assign wait_done = (wait_cnt == WLAST);
  assign last_bit  = busy_q && (bit_cnt == 7'd64);
  assign nxt_idx   = (state == WAIT) ? '0 : idx + 1'b1;

  always_comb begin
    entry = INIT_TABLE[20:0];
    for (int i = 0; i < NI; i++) begin
      if (nxt_idx == IW'(i)) entry = INIT_TABLE[i*21 +: 21];
    end
  end

  // Command frames use the captured command, init frames the table.
  assign st_wr   = (state == FRAME) ? cmd_wr_q : 1'b1;
  assign st_reg  = (state == FRAME) ? cmd_regad_q : entry[20:16];
  assign st_data = (state == FRAME) ? cmd_wdata_q : entry[15:0];

  assign start = fall && (
    (state == WAIT && wait_done && NUM_INIT > 0) ||
    (state == INIT && last_bit && idx != ILAST) ||
    (state == FRAME && !busy_q));

  assign tx_word = {2'b01, fr_wr ? 2'b01 : 2'b10,
                    fr_phy, fr_reg, 2'b10, fr_data};
  assign nbit    = bit_cnt + 7'd1;

  // Bits 32..63 map onto tx_word MSB first.
  always_comb begin
    drv_o = 1'b1;
    drv_t = 1'b0;
    if (nbit >= 7'd64) begin
      drv_t = 1'b1;
    end else if (nbit >= 7'd32) begin
      drv_o = tx_word[~nbit[4:0]];
      if (!fr_wr && nbit >= 7'd46) begin
        drv_t = 1'b1;
        drv_o = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= WAIT;
      div_cnt     <= '0;
      mdc_q       <= 1'b0;
      wait_cnt    <= '0;
      idx         <= '0;
      bit_cnt     <= '0;
      busy_q      <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_t_q    <= 1'b1;
      cmd_ready_q <= 1'b0;
      complete_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_pend     <= 1'b0;
      rd_data_q   <= '0;
      rx_sh       <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_regad_q <= '0;
      cmd_wdata_q <= '0;
      fr_wr       <= 1'b0;
      fr_phy      <= '0;
      fr_reg      <= '0;
      fr_data     <= '0;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        mdc_q   <= ~mdc_q;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      rd_valid_q <= rd_pend;
      rd_pend    <= 1'b0;
      if (rd_pend) rd_data_q <= rx_sh;

      if (rise && busy_q && !fr_wr &&
          bit_cnt >= 7'd48 && bit_cnt <= 7'd63) begin
        rx_sh   <= {rx_sh[14:0], MDIO_I};
        rd_pend <= (bit_cnt == 7'd63);
      end

      if (fall && busy_q) begin
        if (last_bit) begin
          busy_q   <= 1'b0;
          mdio_o_q <= 1'b1;
          mdio_t_q <= 1'b1;
        end else begin
          bit_cnt  <= nbit;
          mdio_o_q <= drv_o;
          mdio_t_q <= drv_t;
        end
      end

      if (start) begin
        busy_q   <= 1'b1;
        bit_cnt  <= '0;
        mdio_o_q <= 1'b1;
        mdio_t_q <= 1'b0;
        fr_wr    <= st_wr;
        fr_phy   <= PHYAD;
        fr_reg   <= st_reg;
        fr_data  <= st_data;
      end

      unique case (state)
        WAIT: begin
          if (fall) begin
            if (wait_done) begin
              if (NUM_INIT > 0) begin
                state <= INIT;
              end else begin
                state       <= READY;
                cmd_ready_q <= 1'b1;
                complete_q  <= 1'b1;
              end
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        INIT: begin
          if (fall && last_bit) begin
            if (idx == ILAST) begin
              state       <= READY;
              cmd_ready_q <= 1'b1;
              complete_q  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        READY: begin
          if (CMD_VALID && cmd_ready_q) begin
            cmd_wr_q    <= CMD_WR;
            cmd_regad_q <= CMD_REGAD;
            cmd_wdata_q <= CMD_WDATA;
            cmd_ready_q <= 1'b0;
            state       <= FRAME;
          end
        end
        FRAME: begin
          if (fall && last_bit) begin
            state       <= READY;
            cmd_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign MDC       = mdc_q;
  assign MDIO_O    = mdio_o_q;
  assign MDIO_T    = mdio_t_q;
  assign CMD_READY = cmd_ready_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_DATA   = rd_data_q;
  assign BUSY      = busy_q;
  assign COMPLETE  = complete_q;

endmodule
